// File: rtl/proto_pkg.sv
// proto_pkg: tokens, error codes and parser states shared by the UART command parser
package proto_pkg;

    localparam logic [7:0] TOK_W     = 8'h77;
    localparam logic [7:0] TOK_L     = 8'h6C;
    localparam logic [7:0] TOK_C     = 8'h63;
    localparam logic [7:0] TOK_R     = 8'h72;
    localparam logic [7:0] TOK_B     = 8'h62;
    localparam logic [7:0] TOK_OPEN  = 8'h7B;
    localparam logic [7:0] TOK_CLOSE = 8'h7D;
    localparam logic [7:0] TOK_LF    = 8'h0A;
    localparam logic [7:0] TOK_0     = 8'h30;
    localparam logic [7:0] TOK_7     = 8'h37;

    localparam logic [2:0] ERR_WIDTH    = 3'd1;
    localparam logic [2:0] ERR_LENGTH   = 3'd2;
    localparam logic [2:0] ERR_COLOR    = 3'd3;
    localparam logic [2:0] ERR_MOVE     = 3'd4;
    localparam logic [2:0] ERR_OVERFLOW = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd6;

    typedef enum logic [2:0] {
        HUNT_W,
        W_ARG,
        HUNT_L,
        L_ARG,
        HUNT_C,
        C_ARG,
        WAIT_OC,
        OPP_MOVES
    } state_t;

    // Header-hunt state that an aborted argument state falls back to
    function automatic state_t hunt_of(state_t s);
        return s == C_ARG ? HUNT_C : s == L_ARG ? HUNT_L : HUNT_W;
    endfunction

    // Board dimensions are legal from 1 up to and including the maximum
    function automatic logic in_range(logic [7:0] v, logic [7:0] max);
        return v != 8'd0 && v <= max;
    endfunction

endpackage

// File: rtl/proto_move_fifo.sv
// proto_move_fifo: synchronous FIFO for opponent moves; a push on a full FIFO is taken only alongside a pop
module proto_move_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_pop;
    logic          do_push;

    assign empty   = level == '0;
    assign full    = level == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage array; no reset needed because the head is masked while empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/proto_rx_parser.sv
// proto_rx_parser: decodes the UART command stream into board setup, turn pulses and a move FIFO
module proto_rx_parser
    import proto_pkg::*;
#(
    parameter logic [7:0] MAX_WIDTH   = 8'd16,
    parameter logic [7:0] MAX_LENGTH  = 8'd24,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         TIMEOUT_CYC = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          RxD_ready,
    input  logic [7:0]                    RxD_data,
    output logic [7:0]                    width,
    output logic                          width_valid,
    output logic [7:0]                    length,
    output logic                          length_valid,
    output logic                          red,
    output logic                          blue,
    output logic                          color_valid,
    output logic                          opp_start,
    output logic                          me_start,
    output logic [7:0]                    mv_data,
    output logic                          mv_valid,
    input  logic                          mv_ready,
    output logic [$clog2(FIFO_DEPTH):0]   mv_level,
    output logic                          err_valid,
    output logic [2:0]                    err_code
);

    localparam logic [31:0] TO = 32'(TIMEOUT_CYC);

    state_t      state;
    logic [31:0] tcnt;
    logic        byte_in;
    logic        in_arg;
    logic        is_move;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        tmo;

    assign byte_in  = RxD_ready && RxD_data != TOK_LF;
    assign in_arg   = state inside {W_ARG, L_ARG, C_ARG};
    assign is_move  = RxD_data >= TOK_0 && RxD_data <= TOK_7;
    assign push     = byte_in && state == OPP_MOVES && is_move;
    assign pop      = mv_valid && mv_ready;
    assign overflow = push && full && !pop;
    assign tmo      = TO != '0 && in_arg && !RxD_ready && tcnt == TO - 1;
    assign mv_valid = !empty;

    proto_move_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (RxD_data),
        .dout  (mv_data),
        .full  (full),
        .empty (empty),
        .level (mv_level)
    );

    // Idle-cycle counter: runs only while waiting for an argument, any received byte restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcnt <= '0;
        else tcnt <= (TO == '0 || !in_arg || RxD_ready || tmo) ? '0 : tcnt + 1'b1;
    end

    // Command FSM with registered setup fields, turn pulses and error reporting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HUNT_W;
            width        <= '0;
            width_valid  <= 1'b0;
            length       <= '0;
            length_valid <= 1'b0;
            red          <= 1'b0;
            blue         <= 1'b0;
            color_valid  <= 1'b0;
            opp_start    <= 1'b0;
            me_start     <= 1'b0;
            err_valid    <= 1'b0;
            err_code     <= '0;
        end else begin
            err_valid <= 1'b0;
            opp_start <= 1'b0;
            me_start  <= 1'b0;
            if (tmo) begin
                err_valid <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                state     <= hunt_of(state);
            end else if (byte_in) begin
                case (state)
                    HUNT_W: if (RxD_data == TOK_W) state <= W_ARG;
                    W_ARG: begin
                        if (in_range(RxD_data, MAX_WIDTH)) begin
                            width       <= RxD_data;
                            width_valid <= 1'b1;
                            state       <= HUNT_L;
                        end else begin
                            err_valid <= 1'b1;
                            err_code  <= ERR_WIDTH;
                            state     <= HUNT_W;
                        end
                    end
                    HUNT_L: if (RxD_data == TOK_L) state <= L_ARG;
                    L_ARG: begin
                        if (in_range(RxD_data, MAX_LENGTH)) begin
                            length       <= RxD_data;
                            length_valid <= 1'b1;
                            state        <= HUNT_C;
                        end else begin
                            err_valid <= 1'b1;
                            err_code  <= ERR_LENGTH;
                            state     <= HUNT_L;
                        end
                    end
                    HUNT_C: if (RxD_data == TOK_C) state <= C_ARG;
                    C_ARG: begin
                        if (RxD_data == TOK_R || RxD_data == TOK_B) begin
                            red         <= RxD_data == TOK_R;
                            blue        <= RxD_data == TOK_B;
                            color_valid <= 1'b1;
                            state       <= WAIT_OC;
                        end else begin
                            err_valid <= 1'b1;
                            err_code  <= ERR_COLOR;
                            state     <= HUNT_C;
                        end
                    end
                    WAIT_OC: begin
                        if (RxD_data == TOK_OPEN) begin
                            opp_start <= 1'b1;
                            state     <= OPP_MOVES;
                        end
                    end
                    OPP_MOVES: begin
                        if (RxD_data == TOK_CLOSE) begin
                            me_start <= 1'b1;
                            state    <= WAIT_OC;
                        end else if (!is_move) begin
                            err_valid <= 1'b1;
                            err_code  <= ERR_MOVE;
                        end else if (overflow) begin
                            err_valid <= 1'b1;
                            err_code  <= ERR_OVERFLOW;
                        end
                    end
                endcase
            end
        end
    end

endmodule
